counter_cmd_sequencer: RTL and testbench

Upstream command stage for the 8-bit functional counter. Accepts {op, d, repeat} commands over a valid/ready handshake and buffers them in a 4-entry FIFO. Replays each command onto the counter's op/d inputs for repeat+1 consecutive clock cycles, then drives HOLD when no command is pending. Lets a controller script count-up, count-down and load sequences without cycle-exact timing.

---
 rtl/counter_cmd_sequencer_pkg.sv | 28 ++
 rtl/counter_cmd_sequencer_if.sv | 30 +++
 rtl/counter_cmd_sequencer_fifo.sv | 65 ++++++
 rtl/counter_cmd_sequencer.sv | 137 +++++++++++++
 tb/tb_counter_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/counter_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// counter_cmd_pkg
// Shared definitions for the counter command sequencer: counter op codes,
// the command record layout and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package counter_cmd_pkg;

    localparam int CMD_DW = 8;
    localparam int CMD_RW = 4;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef struct packed {
        logic [1:0]        op;
        logic [CMD_DW-1:0] d;
        logic [CMD_RW-1:0] rep;
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// counter_cmd_sequencer_if
// Command handshake bundle between a controller (master) and the sequencer
// (slave).
//   cmd_valid : master -> slave, command present
//   cmd_ready : slave -> master, command can be accepted this cycle
//   cmd_op    : master -> slave, counter op code
//   cmd_d     : master -> slave, load data
//   cmd_rep   : master -> slave, extra issue cycles (0 = issue once)
// -----------------------------------------------------------------------------
interface counter_cmd_sequencer_if #(
    parameter int DW = 8,
    parameter int RW = 4
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_d;
    logic [RW-1:0] cmd_rep;

    modport master (
        output cmd_valid, cmd_op, cmd_d, cmd_rep,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_d, cmd_rep,
        output cmd_ready
    );
endinterface

// File: rtl/counter_cmd_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous DEPTH-entry FIFO holding flattened commands.
//   clk, clr_n : clock, synchronous active-low reset
//   push_i     : write wdata_i at the tail
//   wdata_i    : command word
//   pop_i      : drop the head entry
//   flush_i    : empty the FIFO (overrides push/pop)
//   head_o     : current head entry, read from storage flops
//   full_o     : level == DEPTH
//   empty_o    : level == 0
//   level_o    : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter  int W     = 14,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [LW-1:0] level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!clr_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (clr_n && !flush_i && push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/counter_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// counter_cmd_sequencer
// Buffers {op, d, rep} commands and replays each onto the counter's op/d
// inputs for rep+1 consecutive cycles, driving HOLD when nothing is pending.
//   clk, clr_n : clock, synchronous active-low reset
//   cmd        : command handshake (slave side)
//   flush      : discard queued and active commands
//   op_out     : registered op to the counter
//   d_out      : registered data to the counter
//   busy       : a command is being issued
//   level      : queued commands, excluding the active one
// -----------------------------------------------------------------------------
module counter_cmd_sequencer
    import counter_cmd_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int RW    = 4,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    clr_n,
    counter_cmd_sequencer_if.slave  cmd,
    input  logic                    flush,
    output logic [1:0]              op_out,
    output logic [DW-1:0]           d_out,
    output logic                    busy,
    output logic [LW-1:0]           level
);

    localparam int CW = 2 + DW + RW;

    logic          clr_n_q;
    logic          full, empty, push, pop;
    logic [CW-1:0] head;
    logic [1:0]    head_op;
    logic [DW-1:0] head_d;
    logic [RW-1:0] head_rep;

    state_t        state_q, state_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [1:0]    op_q, op_d;
    logic [DW-1:0] d_q, d_d;

    // Registered copy of reset keeps cmd_ready low in the cycle after a
    // reset edge, independent of any same-cycle pop.
    always_ff @(posedge clk) begin
        clr_n_q <= clr_n;
    end

    assign cmd.cmd_ready = clr_n_q & ~full;
    assign push          = cmd.cmd_valid & cmd.cmd_ready & ~flush;

    cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clr_n   (clr_n),
        .push_i  (push),
        .wdata_i ({cmd.cmd_op, cmd.cmd_d, cmd.cmd_rep}),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign head_op  = head[CW-1 -: 2];
    assign head_d   = head[RW +: DW];
    assign head_rep = head[RW-1:0];

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        op_d    = op_q;
        d_d     = d_q;
        pop     = 1'b0;
        if (flush) begin
            state_d = IDLE;
            rep_d   = '0;
            op_d    = OP_HOLD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        op_d    = head_op;
                        d_d     = head_d;
                        rep_d   = head_rep;
                        state_d = ISSUE;
                    end else begin
                        op_d = OP_HOLD;
                    end
                end
                ISSUE: begin
                    if (rep_q != '0) begin
                        rep_d = rep_q - 1'b1;
                    end else if (!empty) begin
                        // Chain straight into the next command: no HOLD bubble.
                        pop   = 1'b1;
                        op_d  = head_op;
                        d_d   = head_d;
                        rep_d = head_rep;
                    end else begin
                        op_d    = OP_HOLD;
                        state_d = IDLE;
                    end
                end
                default: begin
                    op_d    = OP_HOLD;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= IDLE;
            rep_q   <= '0;
            op_q    <= OP_HOLD;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            op_q    <= op_d;
            d_q     <= d_d;
        end
    end

    assign op_out = op_q;
    assign d_out  = d_q;
    assign busy   = (state_q == ISSUE);

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
module tb_counter_cmd_sequencer;
    import counter_cmd_pkg::*;

    localparam int DW    = 8;
    localparam int RW    = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    op_out;
    logic [DW-1:0] d_out;
    logic          busy;
    logic [LW-1:0] level;

    counter_cmd_sequencer_if #(.DW(DW), .RW(RW)) cif ();

    counter_cmd_sequencer #(.DW(DW), .RW(RW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .cmd    (cif.slave),
        .flush  (flush),
        .op_out (op_out),
        .d_out  (d_out),
        .busy   (busy),
        .level  (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending commands plus the active one and
    // how many more cycles it must stay on the output.
    cmd_t          mq[$];
    cmd_t          mc;
    int            mrem = 0;
    bit            mbusy = 0;
    logic [1:0]    mop = OP_HOLD;
    logic [DW-1:0] md = '0;
    bit            mclr_q = 0;
    bit            mvld = 0;
    bit            macc;

    always @(posedge clk) begin
        macc = cif.cmd_valid && mclr_q && (mq.size() < DEPTH);
        if (!clr_n) begin
            mq.delete();
            mrem = 0; mbusy = 0; mop = OP_HOLD; md = '0;
        end else if (flush) begin
            mq.delete();
            mrem = 0; mbusy = 0; mop = OP_HOLD;
        end else begin
            if (mbusy && mrem > 0) begin
                mrem--;
            end else if (mq.size() > 0) begin
                mc = mq.pop_front();
                mop = mc.op; md = mc.d; mrem = int'(mc.rep); mbusy = 1;
            end else begin
                mop = OP_HOLD; mbusy = 0;
            end
            if (macc) mq.push_back('{op: cif.cmd_op, d: cif.cmd_d, rep: cif.cmd_rep});
        end
        mclr_q = clr_n;
        mvld = 1;
    end

    always @(negedge clk) begin
        if (mvld) begin
            chk("op_out",    op_out, mop);
            chk("d_out",     d_out, md);
            chk("busy",      busy, mbusy);
            chk("level",     level, mq.size());
            chk("cmd_ready", cif.cmd_ready, (mclr_q && mq.size() < DEPTH));
        end
    end

    task automatic push(input logic [1:0] op, input logic [DW-1:0] d, input logic [RW-1:0] rep);
        bit ok = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op = op; cif.cmd_d = d; cif.cmd_rep = rep;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = cif.cmd_ready;
            @(posedge clk); #1;
        end
        cif.cmd_valid = 1'b0;
        chk("push_accept", ok, 1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (!busy && level == 0);
        end
        chk("drain_done", done, 1);
        @(posedge clk); #1;
    endtask

    int e1[5];
    int e2[4];

    initial begin
        cif.cmd_valid = 1'b1;
        cif.cmd_op = OP_UP; cif.cmd_d = 8'hA5; cif.cmd_rep = 4'd1;

        // Reset held with a command presented.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_op", op_out, 0);
        chk("rst_d", d_out, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cif.cmd_ready, 0);
        clr_n = 1'b1;
        cif.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Single command {UP, 0x0F, rep=2}.
        e1 = '{0, 1, 1, 1, 0};
        push(OP_UP, 8'h0F, 4'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("single_op", op_out, e1[i]);
            if (e1[i] == 1) chk("single_d", d_out, 8'h0F);
        end
        chk("single_busy_end", busy, 0);
        @(posedge clk); #1;

        // Back-to-back, no HOLD gap between commands.
        e2 = '{2, 2, 1, 0};
        push(OP_LOAD, 8'hFF, 4'd0);
        push(OP_DOWN, 8'h00, 4'd1);
        push(OP_UP,   8'h00, 4'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_op", op_out, e2[i]);
        end
        drain();

        // Fill the FIFO behind a long command.
        for (int i = 0; i < 5; i++) push(2'(i % 3 + 1), 8'(8'h10 + i), 4'd15);
        @(negedge clk);
        chk("full_level", level, 4);
        chk("full_ready", cif.cmd_ready, 0);
        @(posedge clk); #1;
        push(OP_LOAD, 8'h60, 4'd15);
        drain();

        // Flush in the third cycle of a rep=7 command with two queued.
        push(OP_UP,   8'h11, 4'd7);
        push(OP_DOWN, 8'h22, 4'd1);
        push(OP_LOAD, 8'h33, 4'd2);
        @(posedge clk); #1;
        flush = 1'b1;
        cif.cmd_valid = 1'b1; cif.cmd_op = OP_DOWN; cif.cmd_d = 8'h44; cif.cmd_rep = 4'd0;
        @(posedge clk); #1;
        flush = 1'b0;
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("flush_op", op_out, 0);
        chk("flush_level", level, 0);
        chk("flush_busy", busy, 0);
        chk("flush_d_kept", d_out, 8'h11);
        @(negedge clk);
        chk("flush_drop", level, 0);
        @(posedge clk); #1;

        // Reset while busy with three queued.
        push(OP_UP,   8'h55, 4'd15);
        push(OP_DOWN, 8'h66, 4'd3);
        push(OP_LOAD, 8'h77, 4'd3);
        push(OP_UP,   8'h88, 4'd3);
        @(negedge clk);
        chk("pre_rst_level", level, 3);
        chk("pre_rst_busy", busy, 1);
        clr_n = 1'b0;
        @(posedge clk); #1;
        clr_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_op", op_out, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_d", d_out, 0);
        chk("mid_rst_ready", cif.cmd_ready, 0);
        @(negedge clk);
        chk("post_rst_op", op_out, 0);
        chk("post_rst_ready", cif.cmd_ready, 1);
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cif.cmd_valid = 1'($urandom_range(0, 1));
            cif.cmd_op    = 2'($urandom);
            cif.cmd_d     = 8'($urandom);
            cif.cmd_rep   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            flush         = ($urandom_range(0, 59) == 0);
            clr_n         = !($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        cif.cmd_valid = 1'b0;
        flush = 1'b0;
        clr_n = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
